// File: rtl/sdiv_driver.sv
// sdiv_driver: serialises a signed divide request onto the St/Dbus divider protocol and returns its result.
// A wait counter aborts with a timeout response if the divider never produces a fresh Rdy rising edge.
module sdiv_driver #(
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [31:0] ReqDividend,
    input  logic [15:0] ReqDivisor,
    output logic        St,
    output logic [15:0] Dbus,
    input  logic [15:0] Quotient,
    input  logic [15:0] Remainder,
    input  logic        V,
    input  logic        Rdy,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [15:0] RspQuotient,
    output logic [15:0] RspRemainder,
    output logic        RspOvf,
    output logic        RspTimeout,
    output logic        Busy
);
    typedef enum logic [2:0] {IDLE, SEND_HI, SEND_LO, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   lo_q, lo_d, dvs_q, dvs_d, dbus_q, dbus_d, quo_q, quo_d, rem_q, rem_d;
    logic          rdy_q, st_q, st_d, vld_q, vld_d, ovf_q, ovf_d, to_q, to_d, rise;

    assign rise = Rdy & ~rdy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        dvs_d   = dvs_q;
        dbus_d  = dbus_q;
        st_d    = st_q;
        vld_d   = vld_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        to_d    = to_q;
        case (state_q)
            IDLE: if (ReqValid) begin
                lo_d    = ReqDividend[15:0];
                dvs_d   = ReqDivisor;
                st_d    = 1'b1;
                dbus_d  = ReqDividend[31:16];
                state_d = SEND_HI;
            end
            SEND_HI: begin
                st_d    = 1'b1;
                dbus_d  = lo_q;
                state_d = SEND_LO;
            end
            SEND_LO: begin
                st_d    = 1'b0;
                dbus_d  = dvs_q;
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // a fresh rising edge beats a simultaneous terminal count
                if (rise || cnt_q == CW'(TIMEOUT - 1)) begin
                    quo_d   = rise ? Quotient : 16'h0;
                    rem_d   = rise ? Remainder : 16'h0;
                    ovf_d   = rise ? V : 1'b0;
                    to_d    = ~rise;
                    vld_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: if (RspReady) begin
                vld_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lo_q    <= '0;
            dvs_q   <= '0;
            dbus_q  <= '0;
            st_q    <= 1'b0;
            vld_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            to_q    <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            dvs_q   <= dvs_d;
            dbus_q  <= dbus_d;
            st_q    <= st_d;
            vld_q   <= vld_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            to_q    <= to_d;
            rdy_q   <= Rdy;
        end
    end

    assign ReqReady     = state_q == IDLE;
    assign Busy         = state_q != IDLE;
    assign St           = st_q;
    assign Dbus         = dbus_q;
    assign RspValid     = vld_q;
    assign RspQuotient  = quo_q;
    assign RspRemainder = rem_q;
    assign RspOvf       = ovf_q;
    assign RspTimeout   = to_q;
endmodule

// File: tb/tb_sdiv_driver.sv
// tb_sdiv_driver: directed checks of the sdiv_driver bus sequence, response capture, timeout and reset.
module tb_sdiv_driver;
    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_ready;
    logic [31:0] req_dividend = 0;
    logic [15:0] req_divisor = 0;
    logic        st;
    logic [15:0] dbus, quotient = 0, remainder = 0;
    logic        v = 0, rdy = 0;
    logic        rsp_valid, rsp_ready = 0, rsp_ovf, rsp_timeout, busy;
    logic [15:0] rsp_quotient, rsp_remainder;
    int          tests = 0, fails = 0;

    sdiv_driver dut (
        .CLK(clk), .Reset(rst), .ReqValid(req_valid), .ReqReady(req_ready),
        .ReqDividend(req_dividend), .ReqDivisor(req_divisor), .St(st), .Dbus(dbus),
        .Quotient(quotient), .Remainder(remainder), .V(v), .Rdy(rdy),
        .RspValid(rsp_valid), .RspReady(rsp_ready), .RspQuotient(rsp_quotient),
        .RspRemainder(rsp_remainder), .RspOvf(rsp_ovf), .RspTimeout(rsp_timeout), .Busy(busy)
    );

    always #5 clk = ~clk;

    // drives one request from IDLE and records the three bus beats; ends with the driver in WAIT
    task automatic issue(input logic [31:0] dd, input logic [15:0] dv,
                         output logic [15:0] b0, b1, b2, output logic s0, s1, s2);
        req_valid = 1; req_dividend = dd; req_divisor = dv;
        @(negedge clk); b0 = dbus; s0 = st;
        req_valid = 0; req_dividend = 32'hDEADBEEF; req_divisor = 16'hBEEF;
        @(negedge clk); b1 = dbus; s1 = st;
        @(negedge clk); b2 = dbus; s2 = st;
    endtask

    task automatic pulse_rdy(input logic [15:0] q, input logic [15:0] r, input logic ov);
        quotient = q; remainder = r; v = ov; rdy = 1;
        @(negedge clk);
        rdy = 0;
    endtask

    task automatic accept_rsp;
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(negedge clk);
        tests++;
        if ({st, dbus, rsp_valid, rsp_quotient, rsp_remainder, rsp_ovf, rsp_timeout, busy, req_ready} !== {1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            fails++; $display("FAIL reset_state: st=%b dbus=%h vld=%b busy=%b rdy=%b expected 0,0000,0,0,1", st, dbus, rsp_valid, busy, req_ready);
        end
        rst = 0;
    endtask

    task automatic test_basic;
        logic [15:0] b0, b1, b2; logic s0, s1, s2;
        issue(32'h0000006F, 16'h0007, b0, b1, b2, s0, s1, s2);
        tests++;
        if ({s0, b0, s1, b1, s2, b2} !== {1'b1, 16'h0000, 1'b1, 16'h006F, 1'b0, 16'h0007}) begin
            fails++; $display("FAIL basic_bus: got %b/%h %b/%h %b/%h expected 1/0000 1/006f 0/0007", s0, b0, s1, b1, s2, b2);
        end
        tests++;
        if (busy !== 1 || req_ready !== 0 || rsp_valid !== 0) begin
            fails++; $display("FAIL basic_busy: busy=%b reqrdy=%b vld=%b expected 1 0 0", busy, req_ready, rsp_valid);
        end
        pulse_rdy(16'h000F, 16'h0006, 0);
        tests++;
        if ({rsp_valid, rsp_quotient, rsp_remainder, rsp_ovf, rsp_timeout} !== {1'b1, 16'h000F, 16'h0006, 1'b0, 1'b0}) begin
            fails++; $display("FAIL basic_rsp: vld=%b q=%h r=%h ovf=%b to=%b expected 1 000f 0006 0 0", rsp_valid, rsp_quotient, rsp_remainder, rsp_ovf, rsp_timeout);
        end
        accept_rsp();
        tests++;
        if (rsp_valid !== 0 || req_ready !== 1 || dbus !== 16'h0007) begin
            fails++; $display("FAIL basic_accept: vld=%b reqrdy=%b dbus=%h expected 0 1 0007", rsp_valid, req_ready, dbus);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] b0, b1, b2; logic s0, s1, s2;
        issue(32'h07FF00BB, 16'hE005, b0, b1, b2, s0, s1, s2);
        tests++;
        if ({s0, b0, s1, b1, s2, b2} !== {1'b1, 16'h07FF, 1'b1, 16'h00BB, 1'b0, 16'hE005}) begin
            fails++; $display("FAIL b2b_bus1: got %b/%h %b/%h %b/%h expected 1/07ff 1/00bb 0/e005", s0, b0, s1, b1, s2, b2);
        end
        pulse_rdy(16'hBFFE, 16'h00C5, 0);
        tests++;
        if ({rsp_valid, rsp_quotient, rsp_remainder, rsp_timeout} !== {1'b1, 16'hBFFE, 16'h00C5, 1'b0}) begin
            fails++; $display("FAIL b2b_rsp1: vld=%b q=%h r=%h to=%b expected 1 bffe 00c5 0", rsp_valid, rsp_quotient, rsp_remainder, rsp_timeout);
        end
        accept_rsp();
        issue(32'hFFFFFE08, 16'h001E, b0, b1, b2, s0, s1, s2);
        tests++;
        if ({s0, b0, s1, b1, s2, b2} !== {1'b1, 16'hFFFF, 1'b1, 16'hFE08, 1'b0, 16'h001E}) begin
            fails++; $display("FAIL b2b_bus2: got %b/%h %b/%h %b/%h expected 1/ffff 1/fe08 0/001e", s0, b0, s1, b1, s2, b2);
        end
        pulse_rdy(16'hFFF0, 16'hFFE8, 0);
        tests++;
        if ({rsp_valid, rsp_quotient, rsp_remainder} !== {1'b1, 16'hFFF0, 16'hFFE8}) begin
            fails++; $display("FAIL b2b_rsp2: vld=%b q=%h r=%h expected 1 fff0 ffe8", rsp_valid, rsp_quotient, rsp_remainder);
        end
        accept_rsp();
    endtask

    task automatic test_overflow;
        logic [15:0] b0, b1, b2; logic s0, s1, s2;
        issue(32'hFFFFFFFF, 16'h0000, b0, b1, b2, s0, s1, s2);
        pulse_rdy(16'h1234, 16'h5678, 1);
        tests++;
        if ({rsp_valid, rsp_ovf, rsp_timeout, rsp_quotient, rsp_remainder} !== {1'b1, 1'b1, 1'b0, 16'h1234, 16'h5678}) begin
            fails++; $display("FAIL ovf_rsp: vld=%b ovf=%b to=%b q=%h r=%h expected 1 1 0 1234 5678", rsp_valid, rsp_ovf, rsp_timeout, rsp_quotient, rsp_remainder);
        end
        v = 0;
        accept_rsp();
    endtask

    task automatic test_timeout(input logic hold_high);
        logic [15:0] b0, b1, b2; logic s0, s1, s2;
        int n;
        quotient = 16'hAAAA; remainder = 16'h5555; v = 1;
        rdy = hold_high;
        if (hold_high) @(negedge clk);
        issue(32'h00010002, 16'h0003, b0, b1, b2, s0, s1, s2);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (rsp_valid) begin n = i; break; end
        end
        tests++;
        if (n !== 64) begin
            fails++; $display("FAIL timeout_latency(hold=%0b): edges=%0d expected 64", hold_high, n);
        end
        tests++;
        if ({rsp_timeout, rsp_ovf, rsp_quotient, rsp_remainder} !== {1'b1, 1'b0, 16'h0, 16'h0}) begin
            fails++; $display("FAIL timeout_rsp(hold=%0b): to=%b ovf=%b q=%h r=%h expected 1 0 0000 0000", hold_high, rsp_timeout, rsp_ovf, rsp_quotient, rsp_remainder);
        end
        rdy = 0; v = 0;
        accept_rsp();
    endtask

    task automatic test_backpressure;
        logic [15:0] b0, b1, b2; logic s0, s1, s2;
        issue(32'h00000064, 16'h000A, b0, b1, b2, s0, s1, s2);
        pulse_rdy(16'h000A, 16'h0000, 0);
        req_valid = 1; req_dividend = 32'h12345678; req_divisor = 16'h0011;
        quotient = 16'h7777; remainder = 16'h8888;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if ({req_ready, st, rsp_valid, rsp_quotient, rsp_remainder} !== {1'b0, 1'b0, 1'b1, 16'h000A, 16'h0000}) begin
                fails++; $display("FAIL bp_hold[%0d]: reqrdy=%b st=%b vld=%b q=%h r=%h expected 0 0 1 000a 0000", i, req_ready, st, rsp_valid, rsp_quotient, rsp_remainder);
            end
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        tests++;
        if ({req_ready, st, rsp_valid} !== {1'b1, 1'b0, 1'b0}) begin
            fails++; $display("FAIL bp_release: reqrdy=%b st=%b vld=%b expected 1 0 0", req_ready, st, rsp_valid);
        end
        @(negedge clk);
        tests++;
        if ({st, dbus, busy} !== {1'b1, 16'h1234, 1'b1}) begin
            fails++; $display("FAIL bp_next_accept: st=%b dbus=%h busy=%b expected 1 1234 1", st, dbus, busy);
        end
        req_valid = 0;
        repeat (2) @(negedge clk);
        pulse_rdy(16'h0001, 16'h0002, 0);
        accept_rsp();
    endtask

    task automatic test_reset_mid(input int beats);
        req_valid = 1; req_dividend = 32'hCAFEF00D; req_divisor = 16'h0123;
        @(negedge clk);
        req_valid = 0;
        repeat (beats) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        tests++;
        if ({st, dbus, rsp_valid, busy} !== {1'b0, 16'h0, 1'b0, 1'b0}) begin
            fails++; $display("FAIL reset_mid(beats=%0d): st=%b dbus=%h vld=%b busy=%b expected 0 0000 0 0", beats, st, dbus, rsp_valid, busy);
        end
        pulse_rdy(16'h4444, 16'h5555, 0);
        repeat (3) @(negedge clk);
        tests++;
        if ({rsp_valid, busy, rsp_quotient} !== {1'b0, 1'b0, 16'h0}) begin
            fails++; $display("FAIL reset_norsp(beats=%0d): vld=%b busy=%b q=%h expected 0 0 0000", beats, rsp_valid, busy, rsp_quotient);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_timeout(0);
        test_timeout(1);
        test_backpressure();
        test_reset_mid(1);
        test_reset_mid(4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
